// File: rtl/smc_pkg.sv
// smc_pkg: shared state encoding and table/bus constants for the SCCB init sequencer
package smc_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, DELAY, FIN} state_t;
  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam logic [7:0]  DLY_SUBADR = 8'hFE;
  localparam logic [1:0]  PHASE_3W   = 2'd3;
  localparam logic        TRANS_WR   = 1'b0;
endpackage

// File: rtl/smc_init_seq_dly.sv
// smc_init_seq_dly: loadable down-counter; zero marks the last cycle of a delay
module smc_init_seq_dly #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] val,
  output logic          zero
);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? val : cnt - CW'(cnt != '0);
  assign zero = cnt <= CW'(1);
endmodule

// File: rtl/smc_init_seq.sv
// smc_init_seq: walks a register table and issues SCCB 3-phase writes.
// Delay entries (sub-address FE) are honoured only with SMC_INIT_SEQ_DELAY_EN defined.
module smc_init_seq
  import smc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TBL_AW   = 5,
  parameter int DLY_UNIT = 1250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [TBL_AW-1:0]   tbl_addr_o,
  input  logic [2*DATA_W-1:0] tbl_data_i,
  output logic [1:0]          phase_amt_o,
  output logic                trans_type_o,
  output logic                ctrl_vld_o,
  input  logic                ctrl_rdy_i,
  output logic [DATA_W-1:0]   tx_sub_adr_o,
  output logic                tx_sub_adr_vld_o,
  input  logic                tx_sub_adr_rdy_i,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_data_vld_o,
  input  logic                tx_data_rdy_i,
  output logic [TBL_AW:0]     entry_cnt_o
);
  state_t state, nxt;
  logic [TBL_AW-1:0] idx;
  logic [2*DATA_W-1:0] entry;
  logic is_end, is_dly, all_done, adv, last, dly_zero, issue_go;
  assign is_end = tbl_data_i == (2*DATA_W)'(END_MARKER);
  assign last = idx == '1;
  // a channel counts as finished once its valid has dropped or is being accepted now
  assign all_done = (!ctrl_vld_o || ctrl_rdy_i) && (!tx_sub_adr_vld_o || tx_sub_adr_rdy_i)
                 && (!tx_data_vld_o || tx_data_rdy_i);
  assign adv = (state == ISSUE && all_done) || (state == DELAY && dly_zero);
  assign issue_go = state == DECODE && !is_end && !is_dly;
`ifdef SMC_INIT_SEQ_DELAY_EN
  localparam int CW = $clog2((2**DATA_W-1)*DLY_UNIT+1);
  assign is_dly = tbl_data_i[2*DATA_W-1:DATA_W] == DATA_W'(DLY_SUBADR);
  smc_init_seq_dly #(.CW(CW)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .load (state == DECODE && is_dly),
    .val  (CW'(tbl_data_i[DATA_W-1:0]) * CW'(DLY_UNIT)),
    .zero (dly_zero)
  );
`else
  assign is_dly   = 1'b0;
  assign dly_zero = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:         nxt = start_i ? FETCH : IDLE;
      FETCH:        nxt = DECODE;
      DECODE:       nxt = is_end ? FIN : is_dly ? DELAY : ISSUE;
      ISSUE, DELAY: nxt = adv ? (last ? FIN : FETCH) : state;
      default:      nxt = IDLE;
    endcase
  end
  always_comb begin
    busy_o = state != IDLE && state != FIN;
    done_o = state == FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= '0;
      entry            <= '0;
      entry_cnt_o      <= '0;
      ctrl_vld_o       <= 1'b0;
      tx_sub_adr_vld_o <= 1'b0;
      tx_data_vld_o    <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        idx         <= '0;
        entry_cnt_o <= '0;
      end
      if (state == DECODE) entry <= tbl_data_i;
      if (adv && !last) idx <= idx + 1'b1;
      if (state == ISSUE && all_done) entry_cnt_o <= entry_cnt_o + 1'b1;
      ctrl_vld_o       <= issue_go || (ctrl_vld_o && !ctrl_rdy_i);
      tx_sub_adr_vld_o <= issue_go || (tx_sub_adr_vld_o && !tx_sub_adr_rdy_i);
      tx_data_vld_o    <= issue_go || (tx_data_vld_o && !tx_data_rdy_i);
    end
  end
  assign tbl_addr_o   = idx;
  assign tx_sub_adr_o = entry[2*DATA_W-1:DATA_W];
  assign tx_data_o    = entry[DATA_W-1:0];
  assign phase_amt_o  = PHASE_3W;
  assign trans_type_o = TRANS_WR;
endmodule

// File: tb/tb_smc_init_seq.sv
// tb_smc_init_seq: scoreboard bench for smc_init_seq (delay checks follow SMC_INIT_SEQ_DELAY_EN)
module tb_smc_init_seq;
  localparam int DW = 8, AW = 5, DU = 4;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, ctrl_vld, sub_vld, data_vld, trans_type;
  logic ctrl_rdy = 0, sub_rdy = 0, data_rdy = 0;
  logic [1:0] phase_amt;
  logic [AW-1:0] tbl_addr;
  logic [2*DW-1:0] tbl_data;
  logic [DW-1:0] tx_sub, tx_data;
  logic [AW:0] entry_cnt;
  logic [15:0] mem [32];
  logic [15:0] exp_q [$];
  logic [15:0] e;
  logic [7:0] cs, cd;
  int n_cmp = 0, n_bad = 0, done_cnt = 0, rmode = 0, icyc = 0;
  bit seen = 0, hc = 0, hs = 0, hd = 0;

  smc_init_seq #(.DATA_W(DW), .TBL_AW(AW), .DLY_UNIT(DU)) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data), .phase_amt_o(phase_amt),
    .trans_type_o(trans_type), .ctrl_vld_o(ctrl_vld), .ctrl_rdy_i(ctrl_rdy),
    .tx_sub_adr_o(tx_sub), .tx_sub_adr_vld_o(sub_vld), .tx_sub_adr_rdy_i(sub_rdy),
    .tx_data_o(tx_data), .tx_data_vld_o(data_vld), .tx_data_rdy_i(data_rdy),
    .entry_cnt_o(entry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tbl_data <= mem[tbl_addr];

  // ready responder first (icyc = cycles since valids rose), then the write monitor
  always @(negedge clk) begin
    if (ctrl_vld || sub_vld || data_vld) begin icyc = seen ? icyc + 1 : 0; seen = 1; end
    else begin icyc = 0; seen = 0; end
    ctrl_rdy = rmode != 2;
    sub_rdy  = rmode == 0 || (rmode == 1 && icyc >= 3);
    data_rdy = rmode == 0 || (rmode == 1 && icyc >= 5);
    if (rst) begin hc = 0; hs = 0; hd = 0; end
    else begin
      if (ctrl_vld && ctrl_rdy) begin
        hc = 1; n_cmp++;
        if ({phase_amt, trans_type} !== 3'b110) begin n_bad++; $display("FAIL ctrl_word: got phase=%0d type=%b, want phase=3 type=0", phase_amt, trans_type); end
      end
      if (sub_vld && sub_rdy) begin hs = 1; cs = tx_sub; end
      if (data_vld && data_rdy) begin hd = 1; cd = tx_data; end
      if (hc && hs && hd) begin
        n_cmp++; hc = 0; hs = 0; hd = 0;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL write_unexpected: got %h%h, want no write", cs, cd); end
        else begin
          e = exp_q.pop_front();
          if ({cs, cd} !== e) begin n_bad++; $display("FAIL write_payload: got %h%h, want %h", cs, cd, e); end
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic clear_tbl();
    for (int i = 0; i < 32; i++) mem[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string nm);
    bit hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin @(negedge clk); hit = done; end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL %s_done: got no done_o pulse, want one", nm); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_width: got done=%b, want 0", nm, done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_after: got %b, want 0", nm, busy); end
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) @(posedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, want 0", done); end
    n_cmp++; if (tbl_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d, want 0", tbl_addr); end
    n_cmp++; if (entry_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d, want 0", entry_cnt); end
    n_cmp++; if ({ctrl_vld, sub_vld, data_vld} !== 3'b000) begin n_bad++; $display("FAIL reset_valids: got %b, want 000", {ctrl_vld, sub_vld, data_vld}); end
    rst = 0; repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got busy=%b, want 0", busy); end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    clear_tbl(); mem[0] = 16'h1234; mem[1] = 16'h5678;
    rmode = 0; exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
    pulse_start(); wait_done("basic");
    repeat (3) @(negedge clk);
    n_cmp++; if (entry_cnt !== 6'd2) begin n_bad++; $display("FAIL basic_cnt: got %0d, want 2", entry_cnt); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_missing: got %0d pending writes, want 0", exp_q.size()); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d pulses, want 1", done_cnt - d0); end
  endtask

  task automatic test_stagger();
    bit hit = 0;
    clear_tbl(); mem[0] = 16'hABCD;
    rmode = 1; exp_q.push_back(16'hABCD);
    pulse_start();
    for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = ctrl_vld; end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL stagger_issue: got no ctrl_vld, want one"); end
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if ({ctrl_vld, sub_vld, data_vld, tbl_addr} !== {k == 0, k <= 3, k <= 5, (k <= 5) ? 5'd0 : 5'd1}) begin
        n_bad++; $display("FAIL stagger_k%0d: got vld=%b%b%b addr=%0d, want vld=%b%b%b addr=%0d", k, ctrl_vld, sub_vld,
          data_vld, tbl_addr, k == 0, k <= 3, k <= 5, (k <= 5) ? 0 : 1);
      end
    end
    wait_done("stagger");
    n_cmp++; if (entry_cnt !== 6'd1 || exp_q.size() != 0) begin n_bad++; $display("FAIL stagger_cnt: got cnt=%0d pending=%0d, want 1/0", entry_cnt, exp_q.size()); end
    rmode = 0;
  endtask

  task automatic test_delay();
    int first[32];
    bit hit = 0;
    int g1 = 3, wcnt = 5;
    foreach (first[i]) first[i] = -1;
    clear_tbl(); mem[0] = 16'h1111; mem[1] = 16'hFE03; mem[2] = 16'h2222; mem[3] = 16'hFE00; mem[4] = 16'h3333;
    rmode = 0;
`ifdef SMC_INIT_SEQ_DELAY_EN
    g1 = 2 + 3 * DU; wcnt = 3;
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
`else
    exp_q.push_back(16'h1111); exp_q.push_back(16'hFE03); exp_q.push_back(16'h2222);
    exp_q.push_back(16'hFE00); exp_q.push_back(16'h3333);
`endif
    pulse_start();
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (busy && first[tbl_addr] < 0) first[tbl_addr] = k;
      hit = done;
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL delay_done: got no done_o pulse, want one"); end
    n_cmp++; if (first[2] - first[1] != g1) begin n_bad++; $display("FAIL delay_gap_fe03: got %0d cycles, want %0d", first[2] - first[1], g1); end
    n_cmp++; if (first[4] - first[3] != 3) begin n_bad++; $display("FAIL delay_gap_fe00: got %0d cycles, want 3", first[4] - first[3]); end
    @(negedge clk);
    n_cmp++; if (entry_cnt !== 6'(wcnt) || exp_q.size() != 0) begin n_bad++; $display("FAIL delay_cnt: got cnt=%0d pending=%0d, want %0d/0", entry_cnt, exp_q.size(), wcnt); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) begin
      mem[i] = {8'(i), 8'(i * 7 + 1)};
      exp_q.push_back(mem[i]);
    end
    rmode = 0;
    pulse_start(); wait_done("full");
    n_cmp++; if (entry_cnt !== 6'd32) begin n_bad++; $display("FAIL full_cnt: got %0d, want 32", entry_cnt); end
    n_cmp++; if (tbl_addr !== 5'd31) begin n_bad++; $display("FAIL full_addr: got %0d, want 31", tbl_addr); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL full_missing: got %0d pending writes, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int d0;
    clear_tbl(); mem[0] = 16'h5A5A; mem[1] = 16'h6B6B;
    rmode = 2;
    pulse_start();
    for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = ctrl_vld; end
    n_cmp++; if ({ctrl_vld, sub_vld, data_vld} !== 3'b111) begin n_bad++; $display("FAIL rstmid_issue: got vld=%b, want 111", {ctrl_vld, sub_vld, data_vld}); end
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({ctrl_vld, sub_vld, data_vld, busy} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_drop: got vld=%b busy=%b, want 000/0", {ctrl_vld, sub_vld, data_vld}, busy); end
    rst = 0; rmode = 0;
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt != d0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: got done=%0d busy=%b, want 0/0", done_cnt - d0, busy); end
    n_cmp++; if (entry_cnt !== '0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d, want 0", entry_cnt); end
    exp_q.push_back(16'h5A5A); exp_q.push_back(16'h6B6B);
    pulse_start(); wait_done("rstmid");
    n_cmp++; if (entry_cnt !== 6'd2 || exp_q.size() != 0) begin n_bad++; $display("FAIL rstmid_rerun: got cnt=%0d pending=%0d, want 2/0", entry_cnt, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    clear_tbl(); mem[0] = 16'h1234; mem[1] = 16'h5678;
    rmode = 1; exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
    pulse_start();
    for (int j = 0; j < 3; j++) begin
      repeat (2) @(posedge clk); @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy%0d: got %b, want 1", j, busy); end
      pulse_start();
    end
    wait_done("b2b");
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d pulses, want 1", done_cnt - d0); end
    n_cmp++; if (entry_cnt !== 6'd2 || exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_cnt: got cnt=%0d pending=%0d, want 2/0", entry_cnt, exp_q.size()); end
    rmode = 0;
  endtask

  initial begin
    clear_tbl();
    test_reset();
    test_basic();
    test_stagger();
    test_delay();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
